// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter timer controller.
// The optional prescaler is enabled with COUNTER_TIMER_PRESCALE_EN.
package counter_pkg;

    localparam int COUNTER_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/counter_core.sv
// Up-counter datapath: synchronous clear has priority over enable.
module counter_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_timer_ctrl.sv
// Timer controller sequencing counter_core: start/stop/pause, one-shot or periodic.
// Define COUNTER_TIMER_PRESCALE_EN to count one tick every PRESCALE cycles.
module counter_timer_ctrl
    import counter_pkg::*;
#(
    parameter int N        = COUNTER_W,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         periodic,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         tc,
    output logic [1:0]   state
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_timer_ctrl: PRESCALE must be >= 1");
    end

    state_e       state_q, state_d;
    logic [N-1:0] limit_q, limit_d;
    logic         periodic_q, periodic_d;
    logic         tc_q, tc_d;
    logic         clr, en, load, run_step, tick, at_limit;
    logic [N-1:0] count_w;

    counter_core #(.N(N)) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .count (count_w)
    );

    assign at_limit = (count_w == limit_q);

`ifdef COUNTER_TIMER_PRESCALE_EN
    localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [DW-1:0] div_q, div_d;

    assign tick = (div_q == DW'(PRESCALE - 1));

    // Divider restarts on any (re)load or abort and only advances while running.
    always_comb begin
        div_d = div_q;
        if (stop || load) begin
            div_d = '0;
        end else if (run_step) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        tc_d       = 1'b0;
        clr        = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        run_step   = 1'b0;
        if (stop) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        load       = 1'b1;
                        state_d    = RUN;
                        limit_d    = limit;
                        periodic_d = periodic;
                        clr        = 1'b1;
                    end
                end
                RUN, PAUSED: begin
                    // Dropping pause in PAUSED counts on the same edge as the return to RUN.
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        state_d  = RUN;
                        run_step = 1'b1;
                        if (tick) begin
                            if (at_limit) begin
                                tc_d = 1'b1;
                                if (periodic_q) begin
                                    clr = 1'b1;
                                end else begin
                                    state_d = DONE;
                                end
                            end else begin
                                en = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            tc_q       <= tc_d;
        end
    end

    assign count = count_w;
    assign busy  = (state_q == RUN) || (state_q == PAUSED);
    assign done  = (state_q == DONE);
    assign tc    = tc_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl with a per-cycle reference model and expected queue.
module tb_counter_timer_ctrl;

    localparam int N        = 8;
    localparam int PRESCALE = 4;
    localparam int W        = 2 + N + 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] count;
    logic         busy, done, tc;
    logic [1:0]   state;

    counter_timer_ctrl #(.N(N), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .limit    (limit),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tc       (tc),
        .state    (state)
    );

    always #5 clk = ~clk;

    // reference model
    logic [1:0]   m_state = 2'd0;
    logic [N-1:0] m_count = '0, m_limit = '0;
    logic         m_per = 1'b0, m_tc = 1'b0;
    int           m_div = 0;

    logic [W-1:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int tc_seen = 0;

    function automatic logic [W-1:0] pack_exp();
        return {m_state, m_count, (m_state == 2'd1 || m_state == 2'd2), (m_state == 2'd3), m_tc};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_count = '0; m_limit = '0; m_per = 1'b0; m_tc = 1'b0; m_div = 0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic pa,
                              input logic pe, input logic [N-1:0] lim);
        logic tk;
`ifdef COUNTER_TIMER_PRESCALE_EN
        tk = (m_div == PRESCALE - 1);
`else
        tk = 1'b1;
`endif
        m_tc = 1'b0;
        if (sp) begin
            m_state = 2'd0; m_count = '0; m_div = 0;
        end else if ((m_state == 2'd0 || m_state == 2'd3) && st) begin
            m_state = 2'd1; m_limit = lim; m_per = pe; m_count = '0; m_div = 0;
        end else if (m_state == 2'd1 || m_state == 2'd2) begin
            if (pa) begin
                m_state = 2'd2;
            end else begin
                m_state = 2'd1;
                m_div = tk ? 0 : m_div + 1;
                if (tk) begin
                    if (m_count == m_limit) begin
                        m_tc = 1'b1;
                        if (m_per) m_count = '0;
                        else m_state = 2'd3;
                    end else begin
                        m_count = m_count + 1'b1;
                    end
                end
            end
        end
    endtask

    // drive one cycle, predict, then compare after the edge
    task automatic step(input string tag, input logic st, input logic sp, input logic pa,
                        input logic pe, input logic [N-1:0] lim);
        logic [W-1:0] e;
        start = st; stop = sp; pause = pa; periodic = pe; limit = lim;
        model_step(st, sp, pa, pe, lim);
        exp_q.push_back(pack_exp());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (tc === 1'b1) tc_seen++;
        chk(tag, {state, count, busy, done, tc}, e);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {state, count, busy, done, tc}, '0);
        reset = 1'b0;
        idle_steps("idle", 2);

        // reset mid-count
        step("rst_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        idle_steps("rst_run", 4);
        chk("rst_pre_cnt", W'(count), W'(4));
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {state, count, busy, done, tc}, '0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        tc_seen = 0;
        idle_steps("rst_after", 3);
        chk("rst_no_tc", W'(tc_seen), W'(0));

        // one-shot limit=5
        tc_seen = 0;
        step("os_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        idle_steps("os_run", 8);
        chk("os_tc_once", W'(tc_seen), W'(1));
        chk("os_done_hold", W'({done, count}), W'({1'b1, 8'd5}));

        // periodic limit=3, then limit=0
        tc_seen = 0;
        step("per_start", 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
        idle_steps("per_run", 12);
        chk("per_tc_3", W'(tc_seen), W'(3));
        step("per_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tc_seen = 0;
        step("per0_start", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        idle_steps("per0_run", 5);
        chk("per0_tc_5", W'(tc_seen), W'(5));
        step("per0_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // pause/resume at count 7
        step("pz_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
        idle_steps("pz_run", 7);
        for (int i = 0; i < 5; i++) step("pz_hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("pz_state", W'({state, count}), W'({2'd2, 8'd7}));
        step("pz_resume", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("pz_resume_8", W'(count), W'(8));
        step("pz_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // priority cases
        step("pr_start_stop", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        chk("pr_idle", W'(state), W'(0));
        step("pr_lim_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        idle_steps("pr_lim_run", 3);
        tc_seen = 0;
        step("pr_stop_tc", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("pr_stop_no_tc", W'({tc_seen[0], count}), W'(0));
        step("pr_run_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
        step("pr_ign", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step("pr_ign_start", 1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
        idle_steps("pr_ign_run", 4);
        chk("pr_orig_limit", W'({state, count}), W'({2'd3, 8'd4}));

`ifdef COUNTER_TIMER_PRESCALE_EN
        // prescaled one-shot: tc 12 cycles after start
        step("ps_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step("ps_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        tc_seen = 0;
        idle_steps("ps_run", 11);
        chk("ps_no_tc_yet", W'(tc_seen), W'(0));
        step("ps_tc", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("ps_tc_12", W'({tc, state}), W'({1'b1, 2'd3}));
`endif

        idle_steps("tail", 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
